coms_uart_rx: RTL and testbench
===============================

// Module: coms_uart_rx
// PURPOSE
//  Oversampling UART receiver feeding the motor-bus frame matcher in coms.
//  - Synchronises the half-duplex RS485 rx line and majority-votes each bit at its centre.
//  - Checks the stop bit, then delivers one byte per rx_data_ready pulse.
//  - Flags framing errors and reports bus idle so the frame matcher can resync.
// PARAMETERS
//  CLK_FREQ_HZ   50_000_000  system clock frequency
//  BAUDRATE      2_000_000   bus bit rate
//  CLKS_PER_BIT  CLK_FREQ_HZ/BAUDRATE (25); must be >= 8
//  HALF_BIT      CLKS_PER_BIT/2, integer division (12)
//  IDLE_BITS     10          idle line duration, in bit times, before bus_idle asserts
// PORTS
//  clk                    in   1   system clock, rising edge
//  reset                  in   1   asynchronous, active-high reset
//  rx_i                   in   1   raw serial line, idle high, LSB first, 8N1
//  rx_data_ready          out  1   one-cycle pulse: rx_data holds a new valid byte
//  rx_data                out  8   last good byte; held until the next good byte
//  framing_error          out  1   one-cycle pulse: stop bit sampled low
//  framing_error_count    out  16  saturating count of framing errors
//  bus_idle               out  1   line high for >= IDLE_BITS*CLKS_PER_BIT clocks while IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; sync flops set to 1 (line idle).
//   - Reset mid-byte aborts the byte: no pulse, no error.
//  Sync: rx_i passes through 2 FFs to give rx_s. All logic uses rx_s only.
//  Bit counter cnt runs 0..CLKS_PER_BIT-1 within a bit.
//   - Samples taken at cnt = HALF_BIT-1, HALF_BIT, HALF_BIT+1.
//   - bit value = majority of the 3 samples.
//  FSM:
//   IDLE:  rx_s==0 -> START, cnt=0.
//   START: at cnt=HALF_BIT+1, majority==1 -> IDLE (glitch; no output).
//          Else at cnt=CLKS_PER_BIT-1 -> DATA, bit index 0.
//   DATA:  at cnt=CLKS_PER_BIT-1, shift majority into shreg[bit index].
//          After bit 7 -> STOP, cnt=0.
//   STOP:  decide at cnt=HALF_BIT+1 (early exit tolerates baud drift).
//          - majority==1: rx_data<=shreg, rx_data_ready=1 for 1 cycle, -> IDLE.
//          - majority==0: framing_error=1 for 1 cycle, count+1 (saturates at 16'hFFFF),
//            rx_data unchanged, -> BREAK.
//   BREAK: wait for rx_s==1, then -> IDLE. A held-low line produces exactly one error.
//  Latency: rx_data_ready rises 9*CLKS_PER_BIT+HALF_BIT+4 clocks after the clk edge
//   that first registers rx_i low. At defaults this is 241.
//  Back-to-back bytes: a new start bit is accepted in the cycle after STOP exits.
//   No dead time beyond the remaining half stop bit.
//  bus_idle:
//   - Counter increments while state==IDLE and rx_s==1; saturates at IDLE_BITS*CLKS_PER_BIT.
//   - bus_idle=1 when saturated.
//   - rx_s==0 or state!=IDLE: counter cleared, bus_idle=0 on the next clock.
//  rx_data_ready and framing_error are never asserted in the same cycle.
// TESTING
//  Defaults throughout. Bytes are sent at exactly 25 clk/bit unless noted.
//  1 Send 0x55.
//    -> rx_data=0x55, rx_data_ready pulses once at clock 241, framing_error=0.
//  2 Send 1C EB 00 DA back-to-back, 1-bit stop only.
//    -> 4 pulses, bytes in that order, no errors.
//  3 rx_i low for 6 clocks, then high.
//    -> back to IDLE, no rx_data_ready, no framing_error.
//  4 Send 0x00 with the stop bit low, hold low 100 bit times, then 0xA3.
//    -> framing_error once, count=1, rx_data unchanged, then 0xA3 received.
//  5 Line high 249 clocks after reset -> bus_idle=0; 250+ -> bus_idle=1.
//    Next start bit -> bus_idle=0.
//  6 Assert reset during data bit 4, release, send 0x3C.
//    -> no output for the aborted byte; 0x3C received correctly.
//  7 Stream 0xF0 at 24 and 26 clk/bit (~4% drift).
//    -> all bytes correct, no framing_error.

Source files
------------

// File: rtl/coms_uart_rx.sv
// rtl/coms_uart_rx.sv - Oversampling 8N1 UART receiver for the coms motor-bus frame matcher
//
// Purpose:
//   Synchronises the RS485 receive line and finds each start bit. It majority-votes
//   three samples around the centre of every bit and assembles LSB-first bytes. It
//   checks the stop bit, flags framing errors and reports a quiet bus so the frame
//   matcher can resynchronise.
//
// Ports:
//   clk                  in   1   system clock, rising edge
//   reset                in   1   asynchronous active-high reset
//   rx_i                 in   1   raw serial line, idle high, LSB first, 8N1
//   rx_data_ready        out  1   one-cycle pulse, rx_data holds a new good byte
//   rx_data              out  8   last good byte, held until the next good byte
//   framing_error        out  1   one-cycle pulse, stop bit sampled low
//   framing_error_count  out  16  saturating framing error count
//   bus_idle             out  1   line high for IDLE_BITS bit times while idle

module coms_uart_rx #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int BAUDRATE     = 2_000_000,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUDRATE,
    parameter int IDLE_BITS    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_i,
    output logic        rx_data_ready,
    output logic [7:0]  rx_data,
    output logic        framing_error,
    output logic [15:0] framing_error_count,
    output logic        bus_idle
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
    localparam int IW       = $clog2(IDLE_MAX + 1);

    // Sample points straddle the bit centre; the last one is also the decision point.
    localparam logic [CW-1:0] C_SAMP0 = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] C_SAMP1 = CW'(HALF_BIT);
    localparam logic [CW-1:0] C_SAMP2 = CW'(HALF_BIT + 1);
    localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] C_IDLE_TOP = IW'(IDLE_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      r_samp;
    logic [7:0]      r_shreg;
    logic [IW-1:0]   r_idle_cnt;

    logic            w_rx_s;
    logic            w_maj_now;
    logic            w_maj_all;
    logic            w_sampling;

    // Two-flop synchroniser, preset to the idle (high) level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // At the last sample point the third sample is still on the line, so the vote
    // uses the live synchronised value. Later in the bit all three are registered.
    assign w_maj_now = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);
    assign w_maj_all = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

    assign w_sampling = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

    // Receive FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state             <= S_IDLE;
            r_cnt               <= '0;
            r_bit_idx           <= '0;
            r_samp              <= 3'b111;
            r_shreg             <= '0;
            rx_data_ready       <= 1'b0;
            rx_data             <= '0;
            framing_error       <= 1'b0;
            framing_error_count <= '0;
        end else begin
            rx_data_ready <= 1'b0;
            framing_error <= 1'b0;

            if (w_sampling) begin
                if (r_cnt == C_SAMP0) r_samp[0] <= w_rx_s;
                if (r_cnt == C_SAMP1) r_samp[1] <= w_rx_s;
                if (r_cnt == C_SAMP2) r_samp[2] <= w_rx_s;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if ((r_cnt == C_SAMP2) && w_maj_now) begin
                        // Line came back high before the start bit centre: a glitch.
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_state   <= S_DATA;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (r_cnt == C_LAST) begin
                        r_shreg[r_bit_idx] <= w_maj_all;
                        r_cnt              <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_STOP: begin
                    // Decide at mid-stop so the next start bit can be caught even
                    // when the sender runs slightly fast.
                    if (r_cnt == C_SAMP2) begin
                        r_cnt <= '0;
                        if (w_maj_now) begin
                            rx_data       <= r_shreg;
                            rx_data_ready <= 1'b1;
                            r_state       <= S_IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            if (framing_error_count != 16'hFFFF) begin
                                framing_error_count <= framing_error_count + 16'd1;
                            end
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_BREAK: begin
                    // A held-low line reports one error, then waits for release.
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Bus idle detector: counts quiet high clocks while the FSM is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
            bus_idle   <= 1'b0;
        end else if ((r_state == S_IDLE) && w_rx_s) begin
            if (r_idle_cnt != C_IDLE_TOP) begin
                r_idle_cnt <= r_idle_cnt + IW'(1);
                bus_idle   <= ((r_idle_cnt + IW'(1)) == C_IDLE_TOP);
            end else begin
                bus_idle <= 1'b1;
            end
        end else begin
            r_idle_cnt <= '0;
            bus_idle   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_coms_uart_rx.sv
// tb/tb_coms_uart_rx.sv - Scoreboard testbench for coms_uart_rx

module tb_coms_uart_rx;

    localparam int CPB = 25;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_i = 1'b1;
    logic        rx_data_ready;
    logic [7:0]  rx_data;
    logic        framing_error;
    logic [15:0] framing_error_count;
    logic        bus_idle;

    coms_uart_rx dut (
        .clk                 (clk),
        .reset               (reset),
        .rx_i                (rx_i),
        .rx_data_ready       (rx_data_ready),
        .rx_data             (rx_data),
        .framing_error       (framing_error),
        .framing_error_count (framing_error_count),
        .bus_idle            (bus_idle)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        logic [15:0] cnt;
        int          at;
    } exp_t;

    exp_t q[$];
    exp_t e;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_err, input logic [7:0] data, input logic [15:0] cnt, input int at);
        exp_t x;
        x.is_err = is_err;
        x.data   = data;
        x.cnt    = cnt;
        x.at     = at;
        q.push_back(x);
    endtask

    task automatic drive(input logic v, input int n);
        rx_i = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int cpb, input logic stop);
        drive(1'b0, cpb);
        for (int i = 0; i < 8; i++) drive(b[i], cpb);
        drive(stop, cpb);
    endtask

    // Monitor: every output pulse is matched against the head of the queue.
    always @(negedge clk) begin
        if (!reset && (rx_data_ready || framing_error)) begin
            check("both_pulses", int'(rx_data_ready & framing_error), 0);
            if (q.size() == 0) begin
                check("unexpected_output", int'({rx_data_ready, framing_error}), 0);
            end else begin
                e = q.pop_front();
                check("event_kind", int'(framing_error), int'(e.is_err));
                check("rx_data", int'(rx_data), int'(e.data));
                if (e.is_err) check("fe_count", int'(framing_error_count), int'(e.cnt));
                if (e.at >= 0) check("latency_cycle", cyc, e.at);
            end
        end
    end

    logic [7:0] t2_bytes [4];

    initial begin
        t2_bytes[0] = 8'h1C;
        t2_bytes[1] = 8'hEB;
        t2_bytes[2] = 8'h00;
        t2_bytes[3] = 8'hDA;

        // Reset state
        reset = 1'b1;
        rx_i  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(rx_data_ready), 0);
        check("rst_data", int'(rx_data), 0);
        check("rst_ferr", int'(framing_error), 0);
        check("rst_fcount", int'(framing_error_count), 0);
        check("rst_idle", int'(bus_idle), 0);
        reset = 1'b0;

        // Bus idle threshold: 249 clocks low, 250 high
        repeat (249) @(negedge clk);
        check("idle_249", int'(bus_idle), 0);
        @(negedge clk);
        check("idle_250", int'(bus_idle), 1);
        repeat (20) @(negedge clk);
        check("idle_held", int'(bus_idle), 1);

        // Single byte 0x55 with latency check; start bit clears bus_idle
        push(1'b0, 8'h55, 16'd0, cyc + 242);
        drive(1'b0, 5);
        check("idle_cleared", int'(bus_idle), 0);
        drive(1'b0, CPB - 5);
        for (int i = 0; i < 8; i++) drive(((8'h55 >> i) & 8'h01) != 0, CPB);
        drive(1'b1, CPB);
        drive(1'b1, 50);
        check("t1_drain", q.size(), 0);

        // Back-to-back bytes, one stop bit
        for (int i = 0; i < 4; i++) begin
            push(1'b0, t2_bytes[i], 16'd0, -1);
            send(t2_bytes[i], CPB, 1'b1);
        end
        drive(1'b1, 100);
        check("t2_drain", q.size(), 0);

        // Start glitch: six clocks low produces nothing
        drive(1'b0, 6);
        drive(1'b1, 400);
        check("t3_ferr_count", int'(framing_error_count), 0);

        // Reset during data bit 4, then a clean 0x3C
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(((8'h3C >> i) & 8'h01) != 0, CPB);
        drive(1'b1, 12);
        reset = 1'b1;
        drive(1'b1, 3);
        check("t6_rst_data", int'(rx_data), 0);
        reset = 1'b0;
        drive(1'b1, 30);
        push(1'b0, 8'h3C, 16'd0, -1);
        send(8'h3C, CPB, 1'b1);
        drive(1'b1, 50);
        check("t6_drain", q.size(), 0);

        // Framing error: 0x00 with low stop, line held low 100 bit times, then 0xA3
        push(1'b1, 8'h3C, 16'd1, -1);
        drive(1'b0, CPB * 10 + CPB * 100);
        drive(1'b1, 50);
        push(1'b0, 8'hA3, 16'd0, -1);
        send(8'hA3, CPB, 1'b1);
        drive(1'b1, 50);
        check("t4_drain", q.size(), 0);
        check("t4_fcount", int'(framing_error_count), 1);
        check("t4_data", int'(rx_data), 8'hA3);

        // Baud drift: 0xF0 at 24 then 26 clocks per bit
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 8'hF0, 16'd0, -1);
            send(8'hF0, 24, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 8'hF0, 16'd0, -1);
            send(8'hF0, 26, 1'b1);
        end
        drive(1'b1, 100);
        check("t7_drain", q.size(), 0);
        check("t7_fcount", int'(framing_error_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
